// File: rtl/mod_mul_pipe.sv
// Three-stage pipelined modular multiplier (Barrett reduction) for the Dilithium and Kyber moduli.
// The three stages advance together on a global enable; a tag and the modulus select travel with each operation.
module mod_mul_pipe #(
  parameter int unsigned WIDTH = 23,
  parameter int unsigned TAG_W = 4,
  parameter int unsigned Q_D   = 8380417,
  parameter int unsigned Q_K   = 3329,
  parameter int unsigned K_D   = 46,
  parameter int unsigned K_K   = 24
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             select_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] c_o,
  output logic [TAG_W-1:0] tag_o,
  output logic             select_o
);

  localparam int unsigned P_W  = 2 * WIDTH;
  localparam int unsigned KY_W = 12;
  localparam int unsigned T_W  = WIDTH + 2;
  localparam int unsigned M_W  = WIDTH + 2;
  localparam int unsigned PM_W = P_W + M_W;

  // Barrett constants floor(2^K / Q), evaluated at elaboration
  localparam logic [M_W-1:0] M_D = M_W'((64'd1 << K_D) / 64'(Q_D));
  localparam logic [M_W-1:0] M_K = M_W'((64'd1 << K_K) / 64'(Q_K));

  localparam logic [P_W-1:0] Q_D_P = P_W'(Q_D);
  localparam logic [P_W-1:0] Q_K_P = P_W'(Q_K);
  localparam logic [T_W-1:0] Q_D_T = T_W'(Q_D);
  localparam logic [T_W-1:0] Q_K_T = T_W'(Q_K);

  logic             en_c;

  logic             v1;
  logic [P_W-1:0]   p1;
  logic             sel1;
  logic [TAG_W-1:0] tag1;

  logic             v2;
  logic [T_W-1:0]   t2;
  logic             sel2;
  logic [TAG_W-1:0] tag2;

  logic [P_W-1:0]   p_c;
  logic [M_W-1:0]   m_c;
  logic [PM_W-1:0]  pm_c;
  logic [P_W-1:0]   qhat_c;
  logic [P_W-1:0]   qq_c;
  logic [T_W-1:0]   t_c;
  logic [T_W-1:0]   q3_c;
  logic [T_W-1:0]   ta_c;
  logic [T_W-1:0]   tb_c;
  logic [WIDTH-1:0] c_c;

  // Whole pipe moves unless a valid result is blocked downstream
  assign en_c    = !valid_o || ready_i;
  assign ready_o = en_c;

  // Stage 1: full product, or 12x12 product for Kyber
  always_comb begin
    p_c = '0;
    if (select_i) p_c = P_W'(a_i[KY_W-1:0]) * P_W'(b_i[KY_W-1:0]);
    else          p_c = P_W'(a_i) * P_W'(b_i);
  end

  // Stage 2: quotient estimate and partial remainder (t < 3q)
  always_comb begin
    m_c    = sel1 ? M_K : M_D;
    pm_c   = PM_W'(p1) * PM_W'(m_c);
    qhat_c = sel1 ? P_W'(pm_c >> K_K) : P_W'(pm_c >> K_D);
    qq_c   = qhat_c * (sel1 ? Q_K_P : Q_D_P);
    t_c    = T_W'(p1 - qq_c);
  end

  // Stage 3: two conditional subtractions bring t into [0, q)
  always_comb begin
    q3_c = sel2 ? Q_K_T : Q_D_T;
    ta_c = (t2 >= q3_c) ? (t2 - q3_c) : t2;
    tb_c = (ta_c >= q3_c) ? (ta_c - q3_c) : ta_c;
    c_c  = WIDTH'(tb_c);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      v1       <= 1'b0;
      p1       <= '0;
      sel1     <= 1'b0;
      tag1     <= '0;
      v2       <= 1'b0;
      t2       <= '0;
      sel2     <= 1'b0;
      tag2     <= '0;
      valid_o  <= 1'b0;
      c_o      <= '0;
      tag_o    <= '0;
      select_o <= 1'b0;
    end else if (en_c) begin
      v1       <= valid_i;
      p1       <= p_c;
      sel1     <= select_i;
      tag1     <= tag_i;
      v2       <= v1;
      t2       <= t_c;
      sel2     <= sel1;
      tag2     <= tag1;
      valid_o  <= v2;
      c_o      <= c_c;
      tag_o    <= tag2;
      select_o <= sel2;
    end
  end

endmodule

// File: tb/tb_mod_mul_pipe.sv
// Self-checking bench for mod_mul_pipe: directed vector table, stall/reset sequences and a
// randomized stream scored against a plain-arithmetic (a*b) mod q reference.
module tb_mod_mul_pipe;

  typedef struct {
    logic [22:0] a;
    logic [22:0] b;
    logic        sel;
    logic [3:0]  tag;
    logic [22:0] c;
  } vec_t;

  typedef struct {
    logic [22:0] c;
    logic [3:0]  tag;
    logic        sel;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        valid_i;
  logic        ready_o;
  logic [22:0] a_i;
  logic [22:0] b_i;
  logic        select_i;
  logic [3:0]  tag_i;
  logic        valid_o;
  logic        ready_i;
  logic [22:0] c_o;
  logic [3:0]  tag_o;
  logic        select_o;

  int n_tests = 0;
  int n_fail  = 0;
  int drv_exp = -1;
  int rdy_mode = 0;
  int cyc = 0;
  int pop_cnt = 0;
  int stall_cnt = 0;
  int pop_cyc[$];
  exp_t sb[$];

  logic        chk_rst = 1'b0;
  logic        hold_v = 1'b0;
  logic [22:0] held_c;
  logic [3:0]  held_tag;
  logic        held_sel;

  mod_mul_pipe dut (
    .clk_i   (clk),
    .rst_i   (rst_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .a_i     (a_i),
    .b_i     (b_i),
    .select_i(select_i),
    .tag_i   (tag_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .c_o     (c_o),
    .tag_o   (tag_o),
    .select_o(select_o)
  );

  always #5 clk = ~clk;

  function automatic logic [22:0] ref_mod(input logic [22:0] a, input logic [22:0] b, input logic sel);
    longint unsigned x;
    if (sel) x = (64'(a[11:0]) * 64'(b[11:0])) % 64'd3329;
    else     x = (64'(a) * 64'(b)) % 64'd8380417;
    return 23'(x);
  endfunction

  task automatic check(input string name, input longint got, input longint exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Downstream ready pattern: 0 = always ready, 1 = random, 2 = never ready
  initial begin
    ready_i = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       ready_i = 1'b1;
        1:       ready_i = 1'($urandom_range(0, 1));
        default: ready_i = 1'b0;
      endcase
    end
  end

  // Scoreboard: sampled on the falling edge, when all inputs for the next edge are settled
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (rst_i) begin
      sb.delete();
      hold_v  = 1'b0;
      chk_rst = 1'b1;
    end else begin
      if (chk_rst) begin
        check("rst_valid_o", valid_o, 0);
        check("rst_c_o", c_o, 0);
        check("rst_tag_o", tag_o, 0);
        check("rst_select_o", select_o, 0);
        chk_rst = 1'b0;
      end
      check("ready_o", ready_o, (!valid_o || ready_i) ? 1 : 0);
      if (hold_v) begin
        check("stall_c_o", c_o, held_c);
        check("stall_tag_o", tag_o, held_tag);
        check("stall_select_o", select_o, held_sel);
      end
      if (valid_o && ready_i) begin
        if (sb.size() == 0) begin
          check("unexpected_output", sb.size(), 1);
        end else begin
          e = sb.pop_front();
          check("c_o", c_o, e.c);
          check("tag_o", tag_o, e.tag);
          check("select_o", select_o, e.sel);
        end
        pop_cnt++;
        pop_cyc.push_back(cyc);
      end
      if (valid_i && ready_o) begin
        e.c   = (drv_exp >= 0) ? 23'(drv_exp) : ref_mod(a_i, b_i, select_i);
        e.tag = tag_i;
        e.sel = select_i;
        sb.push_back(e);
      end
      if (valid_o && !ready_i) stall_cnt++;
      hold_v   = valid_o && !ready_i;
      held_c   = c_o;
      held_tag = tag_o;
      held_sel = select_o;
    end
  end

  // Entered and left at posedge+1; holds the operation until it is accepted
  task automatic drive_op(input logic [22:0] a, input logic [22:0] b, input logic sel,
                          input logic [3:0] tag, input int exp);
    int n = 0;
    valid_i  = 1'b1;
    a_i      = a;
    b_i      = b;
    select_i = sel;
    tag_i    = tag;
    drv_exp  = exp;
    #1;
    while (!ready_o && n < 500) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (n >= 500) check("drive_timeout", n, 0);
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    drv_exp = -1;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || valid_o) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_empty", sb.size(), 0);
  endtask

  task automatic check_contig(input string name, input int cnt);
    check({name, "_count"}, pop_cyc.size(), cnt);
    if (pop_cyc.size() == cnt && cnt > 0)
      check({name, "_gapless"}, pop_cyc[cnt-1] - pop_cyc[0], cnt - 1);
  endtask

  function automatic logic [22:0] rand_operand();
    case ($urandom_range(0, 3))
      0:       return 23'($urandom);
      1:       return 23'(8380416 - $urandom_range(0, 3));
      2:       return 23'(23'h7FFFFF - $urandom_range(0, 3));
      default: return 23'($urandom_range(0, 4095));
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[9];
    int   n;
    int   pops0;

    tbl[0] = '{23'd2,       23'd4190209, 1'b0, 4'd1, 23'd1};
    tbl[1] = '{23'd3328,    23'd2,       1'b1, 4'd2, 23'd3327};
    tbl[2] = '{23'd0,       23'd123,     1'b0, 4'd3, 23'd0};
    tbl[3] = '{23'd1664,    23'd2,       1'b1, 4'd4, 23'd3328};
    tbl[4] = '{23'd3328,    23'd3328,    1'b1, 4'd5, 23'd1};
    tbl[5] = '{23'h001005,  23'h7FF007,  1'b1, 4'd6, 23'd35};
    tbl[6] = '{23'h7FFFFF,  23'h7FFFFF,  1'b0, 4'd7, 23'd32764};
    tbl[7] = '{23'd4095,    23'd4095,    1'b1, 4'd8, 23'd852};
    tbl[8] = '{23'd8380416, 23'd8380416, 1'b0, 4'd9, 23'd1};

    rst_i = 1'b1; valid_i = 1'b0; a_i = '0; b_i = '0; select_i = 1'b0; tag_i = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_i = 1'b0;

    // Single Dilithium op: result appears exactly three edges after acceptance
    drive_op(23'd8380416, 23'd8380416, 1'b0, 4'd3, 1);
    n = 1;
    while (!valid_o && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("latency", n, 3);
    check("latency_c_o", c_o, 1);
    check("latency_tag_o", tag_o, 3);
    drain();

    // Back-to-back table stream with alternating moduli
    pop_cyc.delete();
    for (int i = 0; i < 9; i++)
      drive_op(tbl[i].a, tbl[i].b, tbl[i].sel, tbl[i].tag, int'(tbl[i].c));
    drain();
    check_contig("stream", 9);

    // Backpressure: four ops against a blocked output
    rdy_mode = 2;
    @(posedge clk); #1;
    @(posedge clk); #1;
    pop_cyc.delete();
    stall_cnt = 0;
    fork
      begin
        for (int k = 0; k < 4; k++)
          drive_op(rand_operand(), rand_operand(), 1'(k), 4'(10 + k), -1);
      end
      begin
        repeat (9) @(posedge clk);
        #1;
        rdy_mode = 0;
      end
    join
    drain();
    check("stall_cycles_ge5", (stall_cnt >= 5) ? 1 : 0, 1);
    check_contig("bp_release", 4);

    // Reset with three operations in flight
    rdy_mode = 2;
    @(posedge clk); #1;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++)
      drive_op(23'(100 + k), 23'(200 + k), 1'b0, 4'(k), -1);
    rst_i = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b0;
    check("mid_rst_valid_o", valid_o, 0);
    rdy_mode = 0;
    pops0 = pop_cnt;
    repeat (10) @(posedge clk);
    #1;
    check("mid_rst_no_stale", pop_cnt - pops0, 0);
    check("mid_rst_sb_empty", sb.size(), 0);

    // Random regression with random downstream ready
    rdy_mode = 1;
    pops0 = pop_cnt;
    for (int k = 0; k < 3000; k++)
      drive_op(rand_operand(), rand_operand(), 1'($urandom_range(0, 1)), 4'(k), -1);
    rdy_mode = 0;
    drain();
    check("random_pop_count", pop_cnt - pops0, 3000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
